func_debounce: RTL and testbench

Front-end conditioning stage that feeds the `funccounter` `funcin` input. It takes a raw, bouncing, asynchronous pushbutton level and synchronizes it to `clockin`, then debounces it with a counted stability window. Each accepted press toggles a registered hold/run mode bit. `funcout` connects directly to `funccounter.funcin`: 1 = hold, 0 = count.

---
 rtl/func_pkg.sv | 15 +
 rtl/sync2.sv | 28 ++
 rtl/func_debounce.sv | 105 ++++++++++
 tb/tb_func_debounce.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/func_pkg.sv
// Shared definitions for the function-key conditioning path.
//   state_e   : debounce FSM states, Gray-ordered so each legal move flips one bit
//   FUNC_HOLD : level of funcout that tells the downstream counter to hold
package func_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_WAIT = 2'b10
  } state_e;

  localparam logic FUNC_HOLD = 1'b1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous level into the clockin domain.
//   clockin : destination clock
//   resetb  : async active-low reset, clears both flops
//   d       : asynchronous input level
//   q       : synchronized level, two edges of latency
module sync2 (
  input  logic clockin,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clockin or negedge resetb) begin
    if (!resetb) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/func_debounce.sv
// Pushbutton conditioner for the funccounter funcin input: synchronizes the
// raw key, debounces it with a DEBN-sample stability window and toggles a
// hold/run mode bit on every accepted press.
//   clockin  : system clock, rising edge
//   resetb   : async active-low reset
//   keyin    : raw, bouncing key level (active high, asynchronous)
//   funcout  : registered mode bit, 1 = hold, 0 = count
//   pressout : one-cycle pulse per accepted press
//   keyout   : debounced key level
module func_debounce
  import func_pkg::*;
#(
  parameter int DEBN = 4,
  parameter int DEBW = 4
) (
  input  logic clockin,
  input  logic resetb,
  input  logic keyin,
  output logic funcout,
  output logic pressout,
  output logic keyout
);

  localparam logic [DEBW-1:0] CNT_MAX = DEBW'(DEBN - 1);
  localparam logic [DEBW-1:0] CNT_ONE = DEBW'(1);

  logic            s;
  state_e          state_q;
  logic [DEBW-1:0] cnt_q;
  logic            func_q;
  logic            press_q;
  logic            key_q;

  sync2 u_sync (
    .clockin (clockin),
    .resetb  (resetb),
    .d       (keyin),
    .q       (s)
  );

  // cnt_q counts consecutive samples at the candidate level, starting at 1
  // on the edge that first sees it; acceptance happens on the edge where a
  // DEBN-th agreeing sample arrives, so cnt_q never passes CNT_MAX.
  always_ff @(posedge clockin or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      func_q  <= ~FUNC_HOLD;
      press_q <= 1'b0;
      key_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s) begin
            cnt_q   <= CNT_ONE;
            state_q <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            state_q <= PRESSED;
            key_q   <= 1'b1;
            press_q <= 1'b1;
            func_q  <= ~func_q;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            cnt_q   <= CNT_ONE;
            state_q <= RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          // A release glitch returns to PRESSED silently: no pulse, no toggle.
          if (s) begin
            cnt_q   <= '0;
            state_q <= PRESSED;
          end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            key_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign funcout  = func_q;
  assign pressout = press_q;
  assign keyout   = key_q;

endmodule

// File: tb/tb_func_debounce.sv
// Scoreboard bench for func_debounce: each driven press pushes its expected
// pulse edge and funcout value; the monitor pops on every pressout pulse.
module tb_func_debounce;

  localparam int DEBN = 4;
  localparam int DEBW = 4;

  typedef struct {
    int   cyc;
    logic func;
  } exp_t;

  logic clockin = 1'b0;
  logic resetb;
  logic keyin;
  logic funcout, pressout, keyout;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_err  = 0;
  logic exp_func = 1'b0;
  exp_t sb[$];
  exp_t e;
  logic [7:0] fc;

  func_debounce #(.DEBN(DEBN), .DEBW(DEBW)) dut (
    .clockin  (clockin),
    .resetb   (resetb),
    .keyin    (keyin),
    .funcout  (funcout),
    .pressout (pressout),
    .keyout   (keyout)
  );

  always #5 clockin = ~clockin;

  // Stand-in for the downstream funccounter: counts while funcout is 0.
  always @(posedge clockin or negedge resetb) begin
    if (!resetb) fc <= '0;
    else if (funcout == 1'b0) fc <= fc + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Press sampled on the edge after this negedge; pulse DEBN+1 edges later.
  task automatic press_now();
    exp_t x;
    keyin    = 1'b1;
    exp_func = ~exp_func;
    x.cyc    = cyc + 1 + DEBN + 1;
    x.func   = exp_func;
    sb.push_back(x);
  endtask

  always @(posedge clockin) begin
    cyc = cyc + 1;
    #1;
    if (pressout === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_press", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("press_cyc",  cyc,     e.cyc);
        chk("press_func", funcout, e.func);
        chk("press_key",  keyout,  1);
      end
    end
  end

  initial begin
    logic pat [7];
    int   c0;
    logic [7:0] fc_a;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Async reset with the key already high: outputs clear before any edge.
    resetb = 1'b0;
    keyin  = 1'b1;
    #2;
    chk("rst0_funcout",  funcout,  0);
    chk("rst0_pressout", pressout, 0);
    chk("rst0_keyout",   keyout,   0);
    keyin = 1'b0;
    repeat (2) @(negedge clockin);
    resetb = 1'b1;
    repeat (3) @(negedge clockin);

    // Clean press held for 100 cycles: one pulse, funcout 0->1.
    press_now();
    repeat (100) @(negedge clockin);
    chk("held_keyout",  keyout,  1);
    chk("held_funcout", funcout, 1);

    // Release glitch of two samples: keyout stays high throughout.
    keyin = 1'b0;
    repeat (2) @(negedge clockin);
    keyin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clockin);
      chk("glitch_keyout", keyout, 1);
    end
    chk("glitch_funcout", funcout, 1);

    // Full release: keyout falls DEBN+1 edges after the first low sample.
    keyin = 1'b0;
    c0 = cyc;
    for (int i = 0; i < DEBN + 4; i++) begin
      @(negedge clockin);
      chk("rel_keyout", keyout, (cyc >= c0 + DEBN + 2) ? 1'b0 : 1'b1);
    end
    chk("rel_funcout", funcout, 1);

    // Downstream counter holds while funcout = 1.
    fc_a = fc;
    repeat (10) @(negedge clockin);
    chk("fc_hold", fc, fc_a);

    // Bounce pattern rejected, then a held press accepted.
    for (int i = 0; i < 7; i++) begin
      keyin = pat[i];
      @(negedge clockin);
    end
    chk("bounce_keyout", keyout, 0);
    press_now();
    repeat (20) @(negedge clockin);
    chk("p2_funcout", funcout, 0);

    // Counter resumes after the second press.
    fc_a = fc;
    repeat (5) @(negedge clockin);
    chk("fc_resume", fc, fc_a + 8'd5);

    // Third press so funcout is 1 before the mid-operation reset.
    keyin = 1'b0;
    repeat (10) @(negedge clockin);
    press_now();
    repeat (10) @(negedge clockin);
    keyin = 1'b0;
    repeat (10) @(negedge clockin);

    // Reset in PRESS_WAIT with cnt = 2: immediate clear, pulse discarded.
    keyin = 1'b1;
    repeat (4) @(negedge clockin);
    #2;
    resetb   = 1'b0;
    exp_func = 1'b0;
    #1;
    chk("rst1_funcout",  funcout,  0);
    chk("rst1_pressout", pressout, 0);
    chk("rst1_keyout",   keyout,   0);
    @(negedge clockin);
    resetb = 1'b1;
    press_now();
    repeat (15) @(negedge clockin);
    chk("p4_keyout", keyout, 1);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
